// File: rtl/clock_pkg.sv
// clock_pkg: state encoding and BCD constants shared by the clock set controller
package clock_pkg;
   typedef enum logic [1:0] {RUN = 2'd0, SET_HR = 2'd1, SET_MIN = 2'd2, SET_SEC = 2'd3} mode_e;
   localparam logic [7:0] BCD_59 = 8'h59;
   localparam logic [7:0] BCD_00 = 8'h00;
   function automatic mode_e next_mode(input mode_e m);
      return mode_e'(m + 2'd1);
   endfunction
endpackage

// File: rtl/btn_repeat.sv
// btn_repeat: one step per rising edge, then auto-repeat while held
module btn_repeat #(
   parameter int REPEAT_DELAY = 8,
   parameter int REPEAT_RATE  = 4
) (
   input  logic i_clk,
   input  logic i_reset_n,
   input  logic i_tick,
   input  logic i_btn,
   input  logic i_block,
   output logic o_press,
   output logic o_step
);
   localparam int CMAX = REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE;
   localparam int CW = $clog2(CMAX + 1);
   logic [CW-1:0] cnt;
   logic armed, btn_q, act, rep, hit;
   always_comb begin
      o_press = armed & i_btn & ~btn_q;
      hit = act & i_tick & (cnt == (rep ? CW'(REPEAT_RATE - 1) : CW'(REPEAT_DELAY - 1)));
      o_step = ~i_block & (o_press | hit);
   end
   // act only arms on a real press, so a level held across reset never repeats
   always_ff @(posedge i_clk or negedge i_reset_n)
      if (!i_reset_n) begin
         armed <= 1'b0;
         btn_q <= 1'b0;
         act <= 1'b0;
         rep <= 1'b0;
         cnt <= '0;
      end else begin
         armed <= 1'b1;
         btn_q <= i_btn;
         if (~i_btn | i_block) begin
            act <= 1'b0;
            rep <= 1'b0;
            cnt <= '0;
         end else if (o_press) begin
            act <= 1'b1;
            rep <= 1'b0;
            cnt <= '0;
         end else if (act & i_tick) begin
            cnt <= hit ? '0 : cnt + 1'b1;
            rep <= rep | hit;
         end
      end
endmodule

// File: rtl/clock_set_controller.sv
// clock_set_controller: RUN-mode seconds prescaler with carry, plus button-driven
// hour/minute/second setting with auto-repeat, idle timeout and blink mask
module clock_set_controller import clock_pkg::*; #(
   parameter int TICKS_PER_SEC = 16,
   parameter int REPEAT_DELAY  = 8,
   parameter int REPEAT_RATE   = 4,
   parameter int TIMEOUT_TICKS = 480
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       i_tick,
   input  logic       i_btn_mode,
   input  logic       i_btn_up,
   input  logic       i_btn_down,
   input  logic [7:0] i_sec_q,
   input  logic [7:0] i_min_q,
   output logic       o_sec_ena,
   output logic       o_sec_up,
   output logic       o_sec_down,
   output logic       o_sec_wr,
   output logic [7:0] o_sec_in,
   output logic       o_min_ena,
   output logic       o_min_up,
   output logic       o_min_down,
   output logic       o_hr_ena,
   output logic       o_hr_up,
   output logic       o_hr_down,
   output logic [1:0] o_mode,
   output logic [2:0] o_blink
);
   localparam int PW = $clog2(TICKS_PER_SEC + 1);
   localparam int IW = $clog2(TIMEOUT_TICKS + 1);
   mode_e state;
   logic [PW-1:0] psc;
   logic [IW-1:0] idle;
   logic [3:0] blink;
   logic armed, mode_q, mode_edge, any_press, sec_step, timeout, blocked;
   logic up_press, up_step, dn_press, dn_step, set_step;
   assign blocked = i_btn_up & i_btn_down;
   btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_up (
      .i_clk(i_clk), .i_reset_n(i_reset_n), .i_tick(i_tick), .i_btn(i_btn_up),
      .i_block(blocked), .o_press(up_press), .o_step(up_step));
   btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_dn (
      .i_clk(i_clk), .i_reset_n(i_reset_n), .i_tick(i_tick), .i_btn(i_btn_down),
      .i_block(blocked), .o_press(dn_press), .o_step(dn_step));
   always_comb begin
      mode_edge = armed & i_btn_mode & ~mode_q;
      any_press = mode_edge | up_press | dn_press;
      sec_step = i_tick & (psc == PW'(TICKS_PER_SEC - 1));
      timeout = i_tick & (idle == IW'(TIMEOUT_TICKS - 1));
      set_step = up_step | dn_step;
   end
   assign o_mode = state;
   assign o_sec_in = BCD_00;
   assign o_blink = {(state == SET_HR) & blink[3], (state == SET_MIN) & blink[3], (state == SET_SEC) & blink[3]};
   // a mode edge outranks any step in the same cycle, and the timeout outranks steps
   always_ff @(posedge i_clk or negedge i_reset_n)
      if (!i_reset_n) begin
         state <= RUN;
         psc <= '0;
         idle <= '0;
         blink <= '0;
         armed <= 1'b0;
         mode_q <= 1'b0;
         {o_sec_ena, o_sec_up, o_sec_down, o_sec_wr, o_min_ena, o_min_up, o_min_down, o_hr_ena, o_hr_up, o_hr_down} <= '0;
      end else begin
         armed <= 1'b1;
         mode_q <= i_btn_mode;
         {o_sec_ena, o_sec_up, o_sec_down, o_sec_wr, o_min_ena, o_min_up, o_min_down, o_hr_ena, o_hr_up, o_hr_down} <= '0;
         if (mode_edge) begin
            state <= next_mode(state);
            idle <= '0;
            if (state == SET_SEC) begin
               psc <= '0;
               blink <= '0;
            end
         end else if (state == RUN) begin
            if (i_tick) psc <= sec_step ? '0 : psc + 1'b1;
            o_sec_ena <= sec_step;
            o_sec_up <= sec_step;
            o_min_ena <= sec_step & (i_sec_q == BCD_59);
            o_min_up <= sec_step & (i_sec_q == BCD_59);
            o_hr_ena <= sec_step & (i_sec_q == BCD_59) & (i_min_q == BCD_59);
            o_hr_up <= sec_step & (i_sec_q == BCD_59) & (i_min_q == BCD_59);
         end else if (timeout) begin
            state <= RUN;
            psc <= '0;
            idle <= '0;
            blink <= '0;
         end else begin
            idle <= any_press ? '0 : idle + IW'(i_tick);
            blink <= blink + 4'(i_tick);
            o_hr_ena <= (state == SET_HR) & set_step;
            o_hr_up <= (state == SET_HR) & up_step;
            o_hr_down <= (state == SET_HR) & dn_step;
            o_min_ena <= (state == SET_MIN) & set_step;
            o_min_up <= (state == SET_MIN) & up_step;
            o_min_down <= (state == SET_MIN) & dn_step;
            o_sec_ena <= (state == SET_SEC) & set_step;
            o_sec_wr <= (state == SET_SEC) & set_step;
            if ((state == SET_SEC) & set_step) psc <= '0;
         end
      end
endmodule

// File: tb/tb_clock_set_controller.sv
// tb_clock_set_controller: directed stimulus with an expected-pulse queue checked by a monitor
module tb_clock_set_controller;
   localparam logic [9:0] SEC_UP     = 10'b1100_000_000;
   localparam logic [9:0] SEC_MIN_UP = 10'b1100_110_000;
   localparam logic [9:0] ALL_UP     = 10'b1100_110_110;
   localparam logic [9:0] SEC_WR     = 10'b1001_000_000;
   localparam logic [9:0] MIN_UP     = 10'b0000_110_000;
   localparam logic [9:0] MIN_DN     = 10'b0000_101_000;
   localparam logic [9:0] HR_UP      = 10'b0000_000_110;
   localparam logic [9:0] HR_DN      = 10'b0000_000_101;
   logic i_clk = 1'b0, i_reset_n = 1'b0, i_tick = 1'b0;
   logic i_btn_mode = 1'b0, i_btn_up = 1'b0, i_btn_down = 1'b0;
   logic [7:0] i_sec_q = 8'h12, i_min_q = 8'h00;
   logic o_sec_ena, o_sec_up, o_sec_down, o_sec_wr, o_min_ena, o_min_up, o_min_down;
   logic o_hr_ena, o_hr_up, o_hr_down;
   logic [7:0] o_sec_in;
   logic [1:0] o_mode;
   logic [2:0] o_blink;
   logic [9:0] pulses, exp_v;
   logic [9:0] exp_q[$];
   int checks = 0, errors = 0;
   assign pulses = {o_sec_ena, o_sec_up, o_sec_down, o_sec_wr, o_min_ena, o_min_up, o_min_down, o_hr_ena, o_hr_up, o_hr_down};
   always #5 i_clk = ~i_clk;
   clock_set_controller dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n), .i_tick(i_tick),
      .i_btn_mode(i_btn_mode), .i_btn_up(i_btn_up), .i_btn_down(i_btn_down),
      .i_sec_q(i_sec_q), .i_min_q(i_min_q),
      .o_sec_ena(o_sec_ena), .o_sec_up(o_sec_up), .o_sec_down(o_sec_down), .o_sec_wr(o_sec_wr),
      .o_sec_in(o_sec_in), .o_min_ena(o_min_ena), .o_min_up(o_min_up), .o_min_down(o_min_down),
      .o_hr_ena(o_hr_ena), .o_hr_up(o_hr_up), .o_hr_down(o_hr_down),
      .o_mode(o_mode), .o_blink(o_blink));
   // monitor: every cycle with any control pulse consumes one expected entry
   always @(negedge i_clk)
      if (i_reset_n && pulses != 10'd0) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse got %b in=%h want none", pulses, o_sec_in);
         end else begin
            exp_v = exp_q.pop_front();
            if ({pulses, o_sec_in} !== {exp_v, 8'h00}) begin
               errors++;
               $display("FAIL pulse got %b in=%h want %b in=00", pulses, o_sec_in, exp_v);
            end
         end
      end
   task automatic step_clk;
      @(posedge i_clk);
      #2;
   endtask
   task automatic tick(input int n);
      repeat (n) begin
         i_tick = 1'b1;
         step_clk();
         i_tick = 1'b0;
         step_clk();
      end
   endtask
   task automatic press_mode(input int n);
      repeat (n) begin
         i_btn_mode = 1'b1;
         step_clk();
         i_btn_mode = 1'b0;
         step_clk();
      end
   endtask
   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, got, want);
      end
   endtask
   task automatic drain(input string name);
      step_clk();
      step_clk();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s got %0d pending pulses want 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask
   task automatic run_second(input string name);
      tick(15);
      drain({name, "_early"});
      exp_q.push_back(i_sec_q == 8'h59 ? (i_min_q == 8'h59 ? ALL_UP : SEC_MIN_UP) : SEC_UP);
      tick(1);
      drain(name);
   endtask
   initial begin
      step_clk();
      step_clk();
      chk("reset_outputs", 32'({pulses, o_mode, o_blink, o_sec_in}), 0);
      i_reset_n = 1'b1;
      step_clk();
      run_second("run_sec");
      i_sec_q = 8'h59;
      run_second("run_min_carry");
      i_min_q = 8'h59;
      run_second("run_hr_carry");
      i_sec_q = 8'h12;
      i_min_q = 8'h00;
      tick(5);
      drain("run_partial");
      press_mode(1);
      chk("mode_set_hr", 32'(o_mode), 1);
      chk("blink_hr_lo", 32'(o_blink), 0);
      tick(8);
      chk("blink_hr_hi", 32'(o_blink), 4);
      tick(8);
      chk("blink_hr_wrap", 32'(o_blink), 0);
      drain("set_hr_hold");
      exp_q.push_back(HR_UP);
      i_btn_up = 1'b1;
      step_clk();
      i_btn_up = 1'b0;
      drain("hr_up");
      exp_q.push_back(HR_DN);
      i_btn_down = 1'b1;
      step_clk();
      i_btn_down = 1'b0;
      drain("hr_down");
      press_mode(1);
      chk("mode_set_min", 32'(o_mode), 2);
      exp_q.push_back(MIN_UP);
      i_btn_up = 1'b1;
      step_clk();
      step_clk();
      i_btn_down = 1'b1;
      step_clk();
      tick(10);
      i_btn_up = 1'b0;
      i_btn_down = 1'b0;
      drain("min_both_held");
      exp_q.push_back(MIN_DN);
      i_btn_down = 1'b1;
      step_clk();
      i_btn_down = 1'b0;
      drain("min_down");
      press_mode(1);
      chk("mode_set_sec", 32'(o_mode), 3);
      exp_q.push_back(SEC_WR);
      i_btn_up = 1'b1;
      drain("sec_press");
      for (int k = 1; k <= 20; k++) begin
         if (k == 8 || k == 12 || k == 16 || k == 20) exp_q.push_back(SEC_WR);
         tick(1);
         drain($sformatf("sec_rep%0d", k));
      end
      i_btn_up = 1'b0;
      step_clk();
      i_btn_mode = 1'b1;
      i_btn_up = 1'b1;
      step_clk();
      i_btn_mode = 1'b0;
      i_btn_up = 1'b0;
      drain("mode_wins");
      chk("mode_back_run", 32'(o_mode), 0);
      chk("blink_run", 32'(o_blink), 0);
      run_second("run_after_sec");
      tick(5);
      press_mode(4);
      chk("mode_cycle_run", 32'(o_mode), 0);
      run_second("run_psc_cleared");
      tick(5);
      press_mode(1);
      tick(479);
      chk("idle_479", 32'(o_mode), 1);
      tick(1);
      chk("timeout_mode", 32'(o_mode), 0);
      chk("timeout_blink", 32'(o_blink), 0);
      drain("timeout_quiet");
      run_second("run_after_timeout");
      press_mode(2);
      chk("mode_min_again", 32'(o_mode), 2);
      exp_q.push_back(MIN_DN);
      i_btn_down = 1'b1;
      step_clk();
      for (int k = 1; k <= 10; k++) begin
         if (k == 8) exp_q.push_back(MIN_DN);
         tick(1);
      end
      drain("min_repeat");
      i_reset_n = 1'b0;
      #1;
      chk("async_reset", 32'({pulses, o_mode, o_blink, o_sec_in}), 0);
      step_clk();
      step_clk();
      i_reset_n = 1'b1;
      step_clk();
      chk("mode_after_reset", 32'(o_mode), 0);
      press_mode(2);
      chk("mode_min_held", 32'(o_mode), 2);
      tick(12);
      i_btn_down = 1'b0;
      drain("no_step_after_reset");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
